// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one fixed-point adder among NUM_REQ requesters.
// Define ADD_SHARE_ARB_SAT_EN for saturating adds; otherwise the sum wraps.
module add_share_arb #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DECIMAL_BITS = 16,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ID_W         = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic                     sum_valid_out,
  input  logic                     sum_ready_in,
  output logic [WIDTH-1:0]         sum_out,
  output logic [ID_W-1:0]          sum_id_out
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : gen_bad_num_req
    $error("add_share_arb: NUM_REQ must be in 2..8");
  end
  if (DECIMAL_BITS >= WIDTH) begin : gen_bad_frac
    $error("add_share_arb: DECIMAL_BITS must be below WIDTH");
  end

  logic             sum_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic [ID_W-1:0]  sum_id_q;
  logic [ID_W-1:0]  ptr_q;

  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];
  logic [ID_W:0]    cand;
  logic [ID_W-1:0]  cand_id;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_found;
  logic             stage_free;
  logic             fire;
  logic [WIDTH-1:0] a_sel, b_sel, sum_raw, sum_res;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = a_in[i*WIDTH +: WIDTH];
      b_arr[i] = b_in[i*WIDTH +: WIDTH];
    end
  end

  // Scan from ptr upward; cand has one spare bit so ptr+k can wrap by subtraction.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    cand_id     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      cand_id = cand[ID_W-1:0];
      if (!grant_found && req_valid_in[cand_id]) begin
        grant_found = 1'b1;
        grant_idx   = cand_id;
      end
    end
  end

  assign stage_free    = !sum_valid_q || sum_ready_in;
  assign fire          = stage_free && grant_found && !reset;
  assign req_ready_out = fire ? (NUM_REQ'(1) << grant_idx) : '0;

  always_comb begin
    a_sel   = a_arr[grant_idx];
    b_sel   = b_arr[grant_idx];
    sum_raw = a_sel + b_sel;
    sum_res = sum_raw;
`ifdef ADD_SHARE_ARB_SAT_EN
    // Same-sign operands producing an opposite-sign result means overflow.
    if (a_sel[WIDTH-1] == b_sel[WIDTH-1] && sum_raw[WIDTH-1] != a_sel[WIDTH-1]) begin
      sum_res = a_sel[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    sum_res = sum_raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_valid_q <= 1'b0;
      sum_q       <= '0;
      sum_id_q    <= '0;
      ptr_q       <= '0;
    end else if (fire) begin
      sum_valid_q <= 1'b1;
      sum_q       <= sum_res;
      sum_id_q    <= grant_idx;
      ptr_q       <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (sum_ready_in) begin
      sum_valid_q <= 1'b0;
    end
  end

  assign sum_valid_out = sum_valid_q;
  assign sum_out       = sum_q;
  assign sum_id_out    = sum_id_q;

endmodule

// File: tb/tb_add_share_arb.sv
// Randomized bench for add_share_arb against a cycle-level reference model.
module tb_add_share_arb;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid_in = '0;
  logic [N-1:0]   req_ready_out;
  logic [N*W-1:0] a_in = '0;
  logic [N*W-1:0] b_in = '0;
  logic           sum_valid_out;
  logic           sum_ready_in = 1'b0;
  logic [W-1:0]   sum_out;
  logic [IDW-1:0] sum_id_out;

  add_share_arb #(
    .WIDTH        (W),
    .DECIMAL_BITS (16),
    .NUM_REQ      (N),
    .ID_W         (IDW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .a_in          (a_in),
    .b_in          (b_in),
    .sum_valid_out (sum_valid_out),
    .sum_ready_in  (sum_ready_in),
    .sum_out       (sum_out),
    .sum_id_out    (sum_id_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model state
  bit          m_valid = 1'b0;
  logic [W-1:0] m_sum  = '0;
  int          m_id    = 0;
  int          m_ptr   = 0;
  logic [63:0] sb[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef ADD_SHARE_ARB_SAT_EN
    if (s > (longint'(1) <<< (W-1)) - 1) s = (longint'(1) <<< (W-1)) - 1;
    if (s < -(longint'(1) <<< (W-1)))    s = -(longint'(1) <<< (W-1));
`endif
    return s[W-1:0];
  endfunction

  function automatic int exp_grant(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  // One clock: check combinational ready, advance model, check registered outputs.
  task automatic cycle(output int g);
    logic [N-1:0] exp_rdy;
    logic [W-1:0] nsum;
    logic [63:0]  front;
    #1;
    g = (reset || !(!m_valid || sum_ready_in)) ? -1 : exp_grant(req_valid_in, m_ptr);
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    check("ready", req_ready_out, exp_rdy);
    if (m_valid && sum_ready_in && !reset) begin
      check("sb_underflow", sb.size() == 0, 0);
      if (sb.size() != 0) begin
        front = sb.pop_front();
        check("retire", {sum_id_out, sum_out}, front);
      end
    end
    nsum = '0;
    if (g >= 0) begin
      nsum = ref_add(a_in[g*W +: W], b_in[g*W +: W]);
      sb.push_back({IDW'(g), nsum});
    end
    @(posedge clk);
    #1;
    if (reset) begin
      m_valid = 1'b0; m_sum = '0; m_id = 0; m_ptr = 0;
      sb.delete();
    end else if (g >= 0) begin
      m_valid = 1'b1; m_sum = nsum; m_id = g; m_ptr = (g + 1) % N;
    end else if (sum_ready_in) begin
      m_valid = 1'b0;
    end
    check("valid", sum_valid_out, m_valid);
    check("sum", sum_out, m_sum);
    check("id", sum_id_out, m_id);
  endtask

  task automatic do_reset();
    int g;
    reset = 1'b1;
    req_valid_in = '0;
    cycle(g);
    reset = 1'b0;
  endtask

  initial begin
    int g;
    do_reset();
    check("rst_valid", sum_valid_out, 0);
    check("rst_sum", sum_out, 0);
    check("rst_id", sum_id_out, 0);

    // Single request
    sum_ready_in = 1'b1;
    set_op(2, 32'h0001_8000, 32'h0002_4000);
    req_valid_in = 4'b0100;
    cycle(g);
    req_valid_in = '0;
    check("single_valid", sum_valid_out, 1);
    check("single_sum", sum_out, 32'h0003_C000);
    check("single_id", sum_id_out, 2);
    cycle(g);
    check("single_pulse", sum_valid_out, 0);
    check("single_hold", sum_out, 32'h0003_C000);

    // All requesters valid: strict rotation
    do_reset();
    sum_ready_in = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, $urandom, $urandom);
    req_valid_in = '1;
    for (int i = 0; i < 8; i++) begin
      cycle(g);
      check("rr_id", sum_id_out, i % N);
      check("rr_valid", sum_valid_out, 1);
      if (g >= 0) set_op(g, $urandom, $urandom);
    end
    req_valid_in = '0;

    // Backpressure
    do_reset();
    sum_ready_in = 1'b1;
    set_op(0, 32'h10, 32'h20);
    req_valid_in = 4'b0001;
    cycle(g);
    req_valid_in = '0;
    sum_ready_in = 1'b0;
    set_op(1, 32'h100, 32'h1);
    set_op(3, 32'h300, 32'h3);
    req_valid_in = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      cycle(g);
      check("bp_ready", req_ready_out, 0);
      check("bp_sum", sum_out, 32'h30);
      check("bp_id", sum_id_out, 0);
    end
    sum_ready_in = 1'b1;
    #1;
    check("bp_grant1", req_ready_out, 4'b0010);
    cycle(g);
    req_valid_in = 4'b1000;
    check("bp_sum1", sum_out, 32'h101);
    #1;
    check("bp_grant3", req_ready_out, 4'b1000);
    cycle(g);
    req_valid_in = '0;
    check("bp_id3", sum_id_out, 3);
    check("bp_sum3", sum_out, 32'h303);

    // Overflow
    set_op(0, 32'h7FFF_0000, 32'h0002_0000);
    req_valid_in = 4'b0001;
    cycle(g);
`ifdef ADD_SHARE_ARB_SAT_EN
    check("ovf_pos", sum_out, 32'h7FFF_FFFF);
`else
    check("ovf_pos", sum_out, 32'h8001_0000);
`endif
    set_op(0, 32'h8000_0000, 32'hFFFF_0000);
    cycle(g);
    req_valid_in = '0;
`ifdef ADD_SHARE_ARB_SAT_EN
    check("ovf_neg", sum_out, 32'h8000_0000);
`else
    check("ovf_neg", sum_out, 32'h7FFF_0000);
`endif

    // Reset mid-stream with a pending result and ptr=3
    do_reset();
    sum_ready_in = 1'b1;
    set_op(2, 32'h5, 32'h6);
    req_valid_in = 4'b0100;
    cycle(g);
    sum_ready_in = 1'b0;
    set_op(0, 32'h7, 32'h8);
    set_op(3, 32'h9, 32'hA);
    req_valid_in = 4'b1001;
    reset = 1'b1;
    cycle(g);
    reset = 1'b0;
    check("mid_rst_valid", sum_valid_out, 0);
    check("mid_rst_sum", sum_out, 0);
    cycle(g);
    check("mid_rst_first", sum_id_out, 0);
    check("mid_rst_sum0", sum_out, 32'hF);
    req_valid_in = 4'b1000;
    sum_ready_in = 1'b1;
    cycle(g);
    check("mid_rst_second", sum_id_out, 3);
    req_valid_in = '0;

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      sum_ready_in = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid_in[i] && $urandom_range(0, 1) == 1) begin
          req_valid_in[i] = 1'b1;
          set_op(i, $urandom, $urandom);
        end
      end
      cycle(g);
      if (g >= 0) req_valid_in[g] = 1'b0;
    end

    // Drain: every accepted transaction must retire exactly once
    req_valid_in = '0;
    sum_ready_in = 1'b1;
    cycle(g);
    cycle(g);
    check("drain", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
